// File: rtl/word8_32bits.sv
// Byte-to-word deserializer: collects BYTE_W-bit bytes MSB-first into a word,
// pulses valid_out on completion and frag_err when a partial word is abandoned.
module word8_32bits #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk_4f,
  input  logic                         reset_L,
  input  logic                         valid_in,
  input  logic [BYTE_W-1:0]            Data_in,
  output logic                         valid_out,
  output logic [BYTE_W*WORD_BYTES-1:0] Data_out,
  output logic                         frag_err,
  output logic [7:0]                   word_cnt
);

  localparam int IDX_W   = $clog2(WORD_BYTES);
  localparam int UPPER_W = BYTE_W * (WORD_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]   idx;
  logic [UPPER_W-1:0] assem;
  logic               last;

  assign last = (idx == LAST_IDX);

  // Only the upper bytes are held; the final byte goes straight into Data_out
  // on the completing edge, so no extra cycle is spent per word.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      idx       <= '0;
      assem     <= '0;
      valid_out <= 1'b0;
      frag_err  <= 1'b0;
      Data_out  <= '0;
      word_cnt  <= '0;
    end else begin
      valid_out <= 1'b0;
      frag_err  <= 1'b0;
      if (valid_in) begin
        if (last) begin
          Data_out  <= {assem, Data_in};
          valid_out <= 1'b1;
          if (word_cnt != '1)
            word_cnt <= word_cnt + 8'd1;
          assem <= '0;
          idx   <= '0;
        end else begin
          for (int unsigned k = 0; k < WORD_BYTES - 1; k++)
            if (idx == IDX_W'(k))
              assem[(WORD_BYTES - 2 - k) * BYTE_W +: BYTE_W] <= Data_in;
          idx <= idx + IDX_W'(1);
        end
      end else if (idx != '0) begin
        frag_err <= 1'b1;
        idx      <= '0;
        assem    <= '0;
      end
    end
  end

endmodule

// File: doc/word8_32bits.md
Name: word8_32bits

Overview:
Byte-to-word deserializer. It is the receive-side counterpart of the 32-bit-to-8-bit serializer.
- Collects a stream of bytes clocked on clk_4f and rebuilds full words, MSB byte first.
- Emits each word with a one-cycle valid pulse.
- Flags frames that break before a word is complete.
- Sits after the serializer/lane in the datapath and feeds the word-side consumer.

Parameters:
BYTE_W, 8, width of one input byte
WORD_BYTES, 4, bytes per output word (power of two, >= 2)

Ports:
clk_4f  input  1  byte-rate clock, rising edge
reset_L  input  1  asynchronous active-low reset
valid_in  input  1  Data_in carries a valid byte this cycle
Data_in  input  BYTE_W  input byte
valid_out  output  1  one-cycle pulse: Data_out holds a newly completed word
Data_out  output  BYTE_W*WORD_BYTES  last completed word, MSB byte = first byte received
frag_err  output  1  one-cycle pulse: valid_in dropped with a partial word pending
word_cnt  output  8  count of completed words since reset, saturates at 255

Behaviour:
- Reset (reset_L=0, asynchronous, any time including mid-word):
  - valid_out=0, frag_err=0, Data_out=0, word_cnt=0.
  - Byte index=0, assembly register=0.
  - On deassertion, the first valid byte is treated as byte 0.
- Byte index: counter 0..WORD_BYTES-1. On every rising edge with valid_in=1:
  - index 0 loads Data_in into the assembly register's most significant byte.
  - index k loads byte position WORD_BYTES-1-k, i.e. for 4 bytes: [31:24], [23:16], [15:8], [7:0].
  - The index then increments, wrapping to 0 after WORD_BYTES-1.
- Word completion, on the edge where index=WORD_BYTES-1 and valid_in=1:
  - Data_out <= assembled upper bytes concatenated with the current Data_in. No extra cycle; back-to-back words are supported.
  - valid_out <= 1 for exactly one cycle.
  - word_cnt increments unless it is already 255.
- Latency: valid_out and Data_out change on the same edge that samples the last byte, so they are visible one cycle after the last byte is presented.
- Throughput: one word per WORD_BYTES cycles with continuous valid_in.
- Data_out holds its value between completions. It is never cleared except by reset and never shows a partial word.
- valid_in=0 with index=0: idle. No change except valid_out<=0 and frag_err<=0.
- valid_in=0 with index!=0 (frame break):
  - Discard the partial word, set index<=0, clear the assembly register.
  - frag_err<=1 for one cycle. Data_out, valid_out and word_cnt are not affected except that valid_out<=0.
  - A new word starts with the next valid byte.
- valid_out and frag_err are never high in the same cycle.
- Data_in is ignored whenever valid_in=0.
- All outputs are registered. No combinational input-to-output paths.

Test Plan:
- Reset, then valid_in=1 with bytes AA,BB,CC,DD on consecutive edges -> one cycle after DD: Data_out=32'hAABBCCDD, valid_out=1 for one cycle, word_cnt=1, frag_err=0.
- Continuous bytes 01..08 -> Data_out=32'h01020304 with valid_out pulse, then 4 cycles later 32'h05060708 with second pulse; word_cnt=2.
- After word 32'h11223344, send bytes 55,66 then drop valid_in for one cycle -> frag_err pulses once, Data_out stays 32'h11223344, word_cnt unchanged. Then send 9A,BC,DE,F0 -> Data_out=32'h9ABCDEF0.
- Assert reset_L=0 asynchronously after 3 bytes of a word -> all outputs 0 immediately. After release, bytes 12,34,56,78 -> Data_out=32'h12345678.
- Loopback with the serializer: feed 32'hDEADBEEF and 32'hCAFEF00D -> identical words appear in order. 300 words -> word_cnt saturates at 255.
